mips16_mc_control: RTL and testbench

- Multi-cycle control sequencer for the mips16bits datapath: 16 x 16-bit register file, separate instruction and data memories, 32-bit instruction word.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables.
- Holds in MEM until data memory acknowledges, with a timeout guard.
- Sits between instruction register opcode/ALU zero flag and the PC, IR, register-file, ALU and data-memory controls.

---
 rtl/mips16_ctrl_pkg.sv | 47 ++++
 rtl/mips16_mc_control_if.sv | 33 +++
 rtl/mips16_alu_op_decode.sv | 30 +++
 rtl/mips16_mc_control.sv | 158 +++++++++++++++
 tb/tb_mips16_mc_control.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips16_ctrl_pkg.sv
// Shared constants for the mips16 multi-cycle control sequencer:
// state encodings, opcodes, ALU operation codes and PC source selects.
package mips16_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_HALTED = 3'b110
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_ANDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_BNE  = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // True for every opcode the sequencer knows how to step through.
    function automatic logic is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_HALT: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips16_mc_control_if.sv
// Control/datapath bundle: the inputs the sequencer observes (start, IR
// opcode, ALU zero, data-memory ack) and every datapath enable it drives.
interface mips16_ctrl_if;

    logic       start;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;

    modport master (
        input  start, opcode, zero, mem_ready,
        output ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst,
               reg_write, mem_to_reg, mem_read, mem_write
    );

    modport slave (
        output start, opcode, zero, mem_ready,
        input  ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst,
               reg_write, mem_to_reg, mem_read, mem_write
    );

endinterface

// File: rtl/mips16_alu_op_decode.sv
// Pure lookup from the latched opcode to the ALU operation, the ALU B-input
// select and the write-back register select. The sequencer decides when
// these values actually reach the datapath.
module mips16_alu_op_decode
    import mips16_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       reg_dst
);

    // Immediate forms and address calculation use the sign-extended field;
    // only R-type writes back to rd.
    always_comb begin
        alu_op  = ALU_FUNCT;
        alu_src = 1'b0;
        reg_dst = 1'b0;
        case (op)
            OP_R:          reg_dst = 1'b1;
            OP_ADDI:       begin alu_op = ALU_ADD; alu_src = 1'b1; end
            OP_ANDI:       begin alu_op = ALU_AND; alu_src = 1'b1; end
            OP_ORI:        begin alu_op = ALU_OR;  alu_src = 1'b1; end
            OP_LW, OP_SW:  begin alu_op = ALU_ADD; alu_src = 1'b1; end
            OP_BEQ, OP_BNE: alu_op = ALU_SUB;
            default:       ;
        endcase
    end

endmodule

// File: rtl/mips16_mc_control.sv
// Multi-cycle control sequencer for the mips16 datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, waits in MEM for the data
// memory ack with a timeout guard, and counts retired instructions.
module mips16_mc_control
    import mips16_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    mips16_ctrl_if.master      bus,
    output logic [2:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               illegal_op,
    output logic               mem_timeout,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic [7:0] wait_cnt;
    logic       retire;
    logic       set_illegal;
    logic       set_timeout;
    logic [2:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_reg_dst;

    mips16_alu_op_decode u_alu_op_decode (
        .op      (op_q),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .reg_dst (dec_reg_dst)
    );

    assign state  = state_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted = (state_q == S_HALTED);

    // State register, latched opcode, MEM wait counter, sticky error flags
    // and the saturating retired-instruction counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= bus.opcode;
            if (state_q == S_EXEC)
                wait_cnt <= '0;
            else if (state_q == S_MEM)
                wait_cnt <= wait_cnt + 8'd1;
            if (set_illegal)
                illegal_op <= 1'b1;
            if (set_timeout)
                mem_timeout <= 1'b1;
            if (retire && (instr_count != '1))
                instr_count <= instr_count + 1'b1;
        end
    end

    // Next state and datapath enables. Enables come from the registered
    // state and op_q; DECODE reads the opcode straight from the IR register,
    // and the branch PC write in EXEC follows the live ALU zero flag.
    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        set_illegal    = 1'b0;
        set_timeout    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_INC;
        bus.alu_op     = ALU_FUNCT;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.ir_write = 1'b1;
                bus.pc_write = 1'b1;
                bus.pc_src   = PC_INC;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                if (bus.opcode == OP_J) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_JUMP;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else if (bus.opcode == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = S_HALTED;
                end else if (!is_legal(bus.opcode)) begin
                    set_illegal = 1'b1;
                    state_d     = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_op  = dec_alu_op;
                bus.alu_src = dec_alu_src;
                if ((op_q == OP_BEQ) || (op_q == OP_BNE)) begin
                    bus.pc_src   = PC_BRANCH;
                    bus.pc_write = (op_q == OP_BEQ) ? bus.zero : ~bus.zero;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.mem_read  = (op_q == OP_LW);
                bus.mem_write = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALTED;
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = dec_reg_dst;
                bus.mem_to_reg = (op_q == OP_LW);
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips16_mc_control.sv
// Scoreboard bench for the mips16 control sequencer: the stimulus process
// drives one cycle at a time and queues the hand-computed outputs for that
// cycle; the monitor pops and compares them on the falling edge.
module tb_mips16_mc_control;
    import mips16_ctrl_pkg::*;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                   ST_MEM = 4, ST_WB = 5, ST_HALTED = 6;

    typedef struct {
        string       tag;
        logic [19:0] ctl;
        logic [15:0] cnt;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [2:0]  state;
    logic        busy, halted, illegal_op, mem_timeout;
    logic [15:0] instr_count;

    exp_t exp_q[$];
    int   checks;
    int   passes;

    mips16_ctrl_if bus ();

    mips16_mc_control #(.MEM_TIMEOUT(15), .COUNT_W(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .state       (state),
        .busy        (busy),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packs the expected outputs in the same order the monitor packs the DUT's.
    function automatic logic [19:0] mk(input int st, input bit irw, input bit pcw,
                                       input logic [1:0] pcs, input logic [2:0] aop,
                                       input bit asrc, input bit rdst, input bit rw,
                                       input bit m2r, input bit mrd, input bit mwr,
                                       input bit ill, input bit tmo);
        bit bsy, hlt;
        bsy = (st != ST_IDLE) && (st != ST_HALTED);
        hlt = (st == ST_HALTED);
        return {3'(st), irw, pcw, pcs, aop, asrc, rdst, rw, m2r, mrd, mwr,
                bsy, hlt, ill, tmo};
    endfunction

    // Drives one cycle of inputs and queues what the DUT must show during it.
    task automatic applyStimulus(input string tag, input bit st, input logic [5:0] op,
                                 input bit z, input bit rdy, input logic [19:0] c,
                                 input logic [15:0] n);
        exp_t e;
        bus.start     = st;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        e.tag = tag;
        e.ctl = c;
        e.cnt = n;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic resetCycle();
        reset_n = 1'b0;
        applyStimulus("reset", 0, OP_R, 0, 0, mk(ST_IDLE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        reset_n = 1'b1;
    endtask

    // Compares one queued expectation against the live DUT outputs.
    task automatic checkOutput(input exp_t e);
        logic [19:0] act;
        act = {state, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src,
               bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.mem_read, bus.mem_write,
               busy, halted, illegal_op, mem_timeout};
        checks++;
        if (act === e.ctl && instr_count === e.cnt)
            passes++;
        else
            $display("[TB] FAIL %s: got ctl=%05h cnt=%0d, expected ctl=%05h cnt=%0d",
                     e.tag, act, instr_count, e.ctl, e.cnt);
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0)
                checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        passes        = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.opcode    = OP_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clock);
        #1;

        // R-type, then LW interrupted by reset while waiting in MEM.
        resetCycle();
        applyStimulus("r_idle",   1, OP_R, 0, 0, mk(ST_IDLE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("r_fetch",  0, OP_R, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("r_decode", 0, OP_R, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("r_exec",   0, OP_R, 0, 0, mk(ST_EXEC,0,0,0,3'b000,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("r_wb",     0, OP_R, 0, 0, mk(ST_WB,0,0,0,0,0,1,1,0,0,0,0,0), 16'd0);
        applyStimulus("lwr_fetch",  0, OP_LW, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd1);
        applyStimulus("lwr_decode", 0, OP_LW, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd1);
        applyStimulus("lwr_exec",   0, OP_LW, 0, 0, mk(ST_EXEC,0,0,0,3'b001,1,0,0,0,0,0,0,0), 16'd1);
        applyStimulus("lwr_mem",    0, OP_LW, 0, 0, mk(ST_MEM,0,0,0,0,0,0,0,0,1,0,0,0), 16'd1);
        reset_n = 1'b0;
        applyStimulus("mid_reset",  0, OP_LW, 0, 0, mk(ST_IDLE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        reset_n = 1'b1;

        // ADDI, LW with three wait cycles, BEQ/BNE, J, SW, then SW timeout.
        applyStimulus("addi_idle",   1, OP_ADDI, 0, 0, mk(ST_IDLE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("addi_fetch",  0, OP_ADDI, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("addi_decode", 0, OP_ADDI, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("addi_exec",   0, OP_ADDI, 0, 0, mk(ST_EXEC,0,0,0,3'b001,1,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("addi_wb",     0, OP_ADDI, 0, 0, mk(ST_WB,0,0,0,0,0,0,1,0,0,0,0,0), 16'd0);
        applyStimulus("lw_fetch",  0, OP_LW, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd1);
        applyStimulus("lw_decode", 0, OP_LW, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd1);
        applyStimulus("lw_exec",   0, OP_LW, 0, 0, mk(ST_EXEC,0,0,0,3'b001,1,0,0,0,0,0,0,0), 16'd1);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("lw_wait%0d", i), 0, OP_LW, 0, 0,
                          mk(ST_MEM,0,0,0,0,0,0,0,0,1,0,0,0), 16'd1);
        applyStimulus("lw_ack",    0, OP_LW, 0, 1, mk(ST_MEM,0,0,0,0,0,0,0,0,1,0,0,0), 16'd1);
        applyStimulus("lw_wb",     0, OP_LW, 0, 0, mk(ST_WB,0,0,0,0,0,0,1,1,0,0,0,0), 16'd1);
        applyStimulus("beq_fetch",  0, OP_BEQ, 1, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd2);
        applyStimulus("beq_decode", 0, OP_BEQ, 1, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd2);
        applyStimulus("beq_exec",   0, OP_BEQ, 1, 0, mk(ST_EXEC,0,1,2'b01,3'b100,0,0,0,0,0,0,0,0), 16'd2);
        applyStimulus("bne_fetch",  0, OP_BNE, 1, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd3);
        applyStimulus("bne_decode", 0, OP_BNE, 1, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd3);
        applyStimulus("bne_exec",   0, OP_BNE, 1, 0, mk(ST_EXEC,0,0,2'b01,3'b100,0,0,0,0,0,0,0,0), 16'd3);
        applyStimulus("j_fetch",  0, OP_J, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd4);
        applyStimulus("j_decode", 0, OP_J, 0, 0, mk(ST_DECODE,0,1,2'b10,0,0,0,0,0,0,0,0,0), 16'd4);
        applyStimulus("sw_fetch",  0, OP_SW, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd5);
        applyStimulus("sw_decode", 0, OP_SW, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd5);
        applyStimulus("sw_exec",   0, OP_SW, 0, 0, mk(ST_EXEC,0,0,0,3'b001,1,0,0,0,0,0,0,0), 16'd5);
        applyStimulus("sw_ack",    0, OP_SW, 0, 1, mk(ST_MEM,0,0,0,0,0,0,0,0,0,1,0,0), 16'd5);
        applyStimulus("swt_fetch",  0, OP_SW, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd6);
        applyStimulus("swt_decode", 0, OP_SW, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd6);
        applyStimulus("swt_exec",   0, OP_SW, 0, 0, mk(ST_EXEC,0,0,0,3'b001,1,0,0,0,0,0,0,0), 16'd6);
        for (int i = 0; i < 15; i++)
            applyStimulus($sformatf("swt_wait%0d", i), 0, OP_SW, 0, 0,
                          mk(ST_MEM,0,0,0,0,0,0,0,0,0,1,0,0), 16'd6);
        for (int i = 0; i < 2; i++)
            applyStimulus($sformatf("swt_halted%0d", i), 1, OP_SW, 0, 0,
                          mk(ST_HALTED,0,0,0,0,0,0,0,0,0,0,0,1), 16'd6);

        // HALT retires and parks the sequencer.
        resetCycle();
        applyStimulus("halt_idle",   1, OP_HALT, 0, 0, mk(ST_IDLE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("halt_fetch",  0, OP_HALT, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("halt_decode", 0, OP_HALT, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("halt_halted", 1, OP_HALT, 0, 0, mk(ST_HALTED,0,0,0,0,0,0,0,0,0,0,0,0), 16'd1);

        // Unknown opcode halts with illegal_op set and is not counted.
        resetCycle();
        applyStimulus("ill_idle",   1, 6'b010101, 0, 0, mk(ST_IDLE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("ill_fetch",  0, 6'b010101, 0, 0, mk(ST_FETCH,1,1,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("ill_decode", 0, 6'b010101, 0, 0, mk(ST_DECODE,0,0,0,0,0,0,0,0,0,0,0,0), 16'd0);
        applyStimulus("ill_halted", 1, 6'b010101, 0, 0, mk(ST_HALTED,0,0,0,0,0,0,0,0,0,0,1,0), 16'd0);

        @(negedge clock);
        @(negedge clock);
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
